// File: rtl/api_pkg.sv
// Shared definitions for the API serial link: word width, frame defaults and slave FSM states.
package api_pkg;
    localparam int API_WORD_W = 32;
    localparam int API_WORK_LEN = 23;
    localparam logic [API_WORD_W-1:0] API_IDLE_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } api_state_e;
endpackage

// File: rtl/api_sync_edge.sv
// Two-flop synchroniser for an asynchronous input with single-cycle rise/fall pulses
// taken from the synchronised level.
module api_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], i_d};
        end
    end

    // r_sync[1] is the synchronised level, r_sync[2] its value one cycle earlier.
    assign o_rise = r_sync[1] & ~r_sync[2];
    assign o_fall = ~r_sync[1] & r_sync[2];
endmodule

// File: rtl/api_miner_slave.sv
// Chip-side responder of the load/sck/mosi/miso link: receives work words and returns
// queued nonces (or the idle word) in the same full-duplex SPI mode 0 frame.
module api_miner_slave
    import api_pkg::*;
#(
    parameter int                    WORK_LEN    = API_WORK_LEN,
    parameter int                    NONCE_DEPTH = 16,
    parameter logic [API_WORD_W-1:0] IDLE_WORD   = API_IDLE_WORD
) (
    input  logic                         CLK_I,
    input  logic                         RST_N_I,
    input  logic                         load,
    input  logic                         sck,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         work_valid,
    output logic [API_WORD_W-1:0]        work_data,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic [7:0]                   word_cnt,
    input  logic                         nonce_push,
    input  logic [API_WORD_W-1:0]        nonce_din,
    output logic                         nonce_full,
    output logic [$clog2(NONCE_DEPTH):0] nonce_cnt
);
    localparam int AW = $clog2(NONCE_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(NONCE_DEPTH);

    api_state_e r_state, w_state_next;

    logic w_load_rise, w_load_fall, w_sck_rise, w_sck_fall;
    logic r_mosi_meta, r_mosi_sync;
    logic r_load_pend;
    logic w_start, w_rx_edge, w_tx_edge, w_done;
    logic w_word_end, w_reload, w_pop, w_push;

    logic [4:0]            r_bit_cnt;
    logic [7:0]            r_word_cnt;
    logic [API_WORD_W-1:0] r_rx_shift, r_tx_shift, r_work_data;
    logic [API_WORD_W-1:0] w_tx_head, w_tx_next;
    logic                  r_miso, r_work_valid, r_frame_done, r_frame_err;

    logic [API_WORD_W-1:0] r_mem [NONCE_DEPTH];
    logic [AW-1:0]         r_rd_ptr, r_wr_ptr;
    logic [AW:0]           r_cnt;

    api_sync_edge u_load_sync (
        .clk    (CLK_I),
        .rst_n  (RST_N_I),
        .i_d    (load),
        .o_rise (w_load_rise),
        .o_fall (w_load_fall)
    );

    api_sync_edge u_sck_sync (
        .clk    (CLK_I),
        .rst_n  (RST_N_I),
        .i_d    (sck),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    // mosi shares the sck synchroniser depth so the sampled bit lines up with the rise pulse.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load_rise || r_load_pend) w_state_next = SHIFT;
            SHIFT:   if (w_load_fall) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_rx_edge = 1'b0;
        w_tx_edge = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE:  w_start = w_load_rise || r_load_pend;
            SHIFT: begin
                w_rx_edge = w_sck_rise;
                w_tx_edge = w_sck_fall;
            end
            DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    assign w_word_end = w_rx_edge && (r_bit_cnt == 5'd31);
    assign w_reload   = w_tx_edge && (r_bit_cnt == 5'd0) && (r_word_cnt != 8'd0);
    assign w_pop      = (w_start || w_reload) && (r_cnt != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
    assign w_push     = nonce_push && ((r_cnt != FULL_CNT) || w_pop);
    assign w_tx_head  = w_pop ? r_mem[r_rd_ptr] : IDLE_WORD;
    assign w_tx_next  = w_reload ? w_tx_head : {r_tx_shift[API_WORD_W-2:0], 1'b0};

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_work_data  <= '0;
            r_miso       <= 1'b0;
            r_work_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_load_pend  <= 1'b0;
        end else begin
            r_work_valid <= 1'b0;
            r_frame_done <= w_done;
            r_frame_err  <= w_done && ((r_word_cnt != 8'(WORK_LEN)) || (r_bit_cnt != 5'd0));
            r_load_pend  <= (r_load_pend || ((r_state == DONE) && w_load_rise)) && !w_start;
            if (w_start) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_rx_shift <= '0;
                r_tx_shift <= w_tx_head;
                r_miso     <= w_tx_head[API_WORD_W-1];
            end
            if (w_rx_edge) begin
                r_rx_shift <= {r_rx_shift[API_WORD_W-2:0], r_mosi_sync};
                r_bit_cnt  <= r_bit_cnt + 5'd1;
                if (w_word_end) begin
                    r_work_data  <= {r_rx_shift[API_WORD_W-2:0], r_mosi_sync};
                    r_work_valid <= 1'b1;
                    if (r_word_cnt != 8'hFF) r_word_cnt <= r_word_cnt + 8'd1;
                end
            end
            if (w_tx_edge) begin
                r_tx_shift <= w_tx_next;
                r_miso     <= w_tx_next[API_WORD_W-1];
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_push) r_mem[r_wr_ptr] <= nonce_din;
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    assign miso       = r_miso;
    assign work_valid = r_work_valid;
    assign work_data  = r_work_data;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign word_cnt   = r_word_cnt;
    assign nonce_full = (r_cnt == FULL_CNT);
    assign nonce_cnt  = r_cnt;
endmodule
